// File: rtl/target_bbox_ctrl.sv
// target_bbox_ctrl
// Per-frame bounding-box tracker for the binary target mask in the VGA pixel
// domain. Accumulates the min/max extent and pixel count of target pixels
// over one frame. After the frame ends, it publishes a registered box together
// with valid/lost status. Short runs of weak frames coast on the last good box.
// The target is declared lost after LOST_FRAMES consecutive weak frames.
module target_bbox_ctrl #(
  parameter int CW          = 11,
  parameter int MAX_X       = 639,
  parameter int MAX_Y       = 479,
  parameter int MIN_HITS    = 16,
  parameter int LOST_FRAMES = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          frame_end,
  input  logic          pix_valid,
  input  logic [CW-1:0] pix_x,
  input  logic [CW-1:0] pix_y,
  input  logic          pix_hit,
  output logic [CW-1:0] box_x0,
  output logic [CW-1:0] box_y0,
  output logic [CW-1:0] box_x1,
  output logic [CW-1:0] box_y1,
  output logic [19:0]   hit_count,
  output logic          box_valid,
  output logic          lost,
  output logic          box_update
);

  localparam int            MW         = $clog2(LOST_FRAMES + 1);
  localparam logic [CW-1:0] MAX_X_C    = CW'(MAX_X);
  localparam logic [CW-1:0] MAX_Y_C    = CW'(MAX_Y);
  localparam logic [19:0]   MIN_HITS_C = 20'(MIN_HITS);
  localparam logic [19:0]   N_SAT      = 20'hFFFFF;
  localparam logic [MW-1:0] LOST_C     = MW'(LOST_FRAMES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;

  logic          acc_init;
  logic          acc_upd;
  logic          commit_take;
  logic          pix_ok;

  logic [CW-1:0] acc_x0;
  logic [CW-1:0] acc_y0;
  logic [CW-1:0] acc_x1;
  logic [CW-1:0] acc_y1;
  logic [19:0]   acc_n;

  logic          commit_pend;
  logic          frame_good;
  logic [MW-1:0] miss_cnt;
  logic [MW:0]   miss_inc;
  logic [MW-1:0] miss_next;

  // A pixel only contributes when it is a valid target pixel inside the active area
  assign pix_ok = pix_valid & pix_hit & (pix_x <= MAX_X_C) & (pix_y <= MAX_Y_C);

  // State register; reset abandons any frame in progress
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: frame_start always restarts the scan and overrides frame_end
  always_comb begin
    state_d     = state_q;
    acc_init    = 1'b0;
    acc_upd     = 1'b0;
    commit_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d  = SCAN;
          acc_init = 1'b1;
        end
      end
      SCAN: begin
        if (frame_start) begin
          state_d  = SCAN;
          acc_init = 1'b1;
        end else begin
          acc_upd = pix_ok;
          if (frame_end) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        if (frame_start) begin
          state_d  = SCAN;
          acc_init = 1'b1;
        end else begin
          state_d     = IDLE;
          commit_take = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Extent and count accumulators; min fields start at the far edge so the first hit wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_x0 <= '0;
      acc_y0 <= '0;
      acc_x1 <= '0;
      acc_y1 <= '0;
      acc_n  <= '0;
    end else if (acc_init) begin
      acc_x0 <= MAX_X_C;
      acc_y0 <= MAX_Y_C;
      acc_x1 <= '0;
      acc_y1 <= '0;
      acc_n  <= '0;
    end else if (acc_upd) begin
      if (pix_x < acc_x0) acc_x0 <= pix_x;
      if (pix_x > acc_x1) acc_x1 <= pix_x;
      if (pix_y < acc_y0) acc_y0 <= pix_y;
      if (pix_y > acc_y1) acc_y1 <= pix_y;
      if (acc_n != N_SAT) acc_n <= acc_n + 20'd1;
    end
  end

  // One-cycle stage between leaving COMMIT and publishing the result.
  // Accumulators cannot move in between because only frame_start touches them in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      commit_pend <= 1'b0;
    end else begin
      commit_pend <= commit_take;
    end
  end

  // A frame counts only with enough hits. The nonzero guard keeps x0<=x1 even if MIN_HITS is 0.
  always_comb begin
    frame_good = (acc_n >= MIN_HITS_C) && (acc_n != 20'd0);
    miss_inc   = {1'b0, miss_cnt} + {{MW{1'b0}}, 1'b1};
    miss_next  = miss_cnt;
    if (miss_inc >= {1'b0, LOST_C}) begin
      miss_next = LOST_C;
    end else begin
      miss_next = miss_inc[MW-1:0];
    end
  end

  // Publish the committed frame; weak frames keep the old box until the miss budget runs out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      box_x0     <= '0;
      box_y0     <= '0;
      box_x1     <= '0;
      box_y1     <= '0;
      hit_count  <= '0;
      box_valid  <= 1'b0;
      lost       <= 1'b1;
      box_update <= 1'b0;
      miss_cnt   <= LOST_C;
    end else begin
      box_update <= commit_pend;
      if (commit_pend) begin
        hit_count <= acc_n;
        if (frame_good) begin
          box_x0    <= acc_x0;
          box_y0    <= acc_y0;
          box_x1    <= acc_x1;
          box_y1    <= acc_y1;
          box_valid <= 1'b1;
          lost      <= 1'b0;
          miss_cnt  <= '0;
        end else begin
          miss_cnt <= miss_next;
          if (miss_next == LOST_C) begin
            box_valid <= 1'b0;
            lost      <= 1'b1;
          end
        end
      end
    end
  end

endmodule
